hub75_scan_driver: RTL and testbench
====================================

# hub75_scan_driver

Scan controller that sits directly downstream of the pattern ROMs (three-rings and siblings) and drives a 64×64 HUB75 panel at 1/32 scan. It generates the `line`/`column` coordinates the combinational pattern LUT consumes and registers the returned six colour bits. It then serialises them onto the panel with shift clock, latch, output-enable and row address.

## Interface
- `COLS`, 64, pixels shifted per scan line; `column` width is clog2(COLS).
- `LINES`, 32, scan lines per frame; `line`/`hub_addr` width is clog2(LINES).
- `CLK_DIV`, 1, half-period of `hub_clk` in `clk` cycles (≥1).
- `LATCH_CYCLES`, 2, width of `hub_lat` high pulse in `clk` cycles (≥1).
- `ON_CYCLES`, 256, cycles with `hub_oe_n` low per line (≥1).

Ports:
- `clk` in 1: single clock. Reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: start/continue scanning; sampled only in IDLE and at line end.
- `line` out 5: row coordinate to pattern source.
- `column` out 6: column coordinate to pattern source.
- `r1`, `r2`, `g1`, `g2`, `b1`, `b2` in 1 each: pattern bits for (`line`, `column`), combinational same cycle.
- `hub_r1`, `hub_r2`, `hub_g1`, `hub_g2`, `hub_b1`, `hub_b2` out 1 each: registered panel data.
- `hub_clk` out 1: panel shift clock.
- `hub_lat` out 1: panel latch, active high.
- `hub_oe_n` out 1: panel output enable, active low.
- `hub_addr` out 5: displayed row address.
- `frame_start` out 1: one-cycle pulse on entering SHIFT for line 0.

## Operation
- FSM states: IDLE, SHIFT, LATCH, DISPLAY.
- IDLE: `hub_oe_n`=1, `hub_clk`=0. Go to SHIFT when `enable`=1, with `column`=0.
- SHIFT: each pixel lasts 2·CLK_DIV cycles.
  - Low phase: `hub_clk`=0 for CLK_DIV cycles. On the first cycle of this phase, `hub_*` data registers load `r1..b2` for the current (`line`, `column`).
  - High phase: `hub_clk`=1 for CLK_DIV cycles.
  - `column` increments at the end of each high phase.
  - After pixel COLS-1 high phase: `hub_clk`→0 and the FSM goes to LATCH. `column` wraps to 0.
- LATCH: on entry, `hub_addr`←`line`. `hub_lat`=1 for LATCH_CYCLES, then the FSM goes to DISPLAY.
- DISPLAY: `hub_oe_n`=0 for ON_CYCLES. At the end, `hub_oe_n`→1 and `line` increments, wrapping LINES-1→0.
  - If `enable`=1, go to SHIFT; otherwise go to IDLE.
- `hub_oe_n`=1 in every state except DISPLAY. There is no shift/display overlap.
- `enable` deasserted mid-line: the current line completes SHIFT, LATCH and DISPLAY, then the FSM goes to IDLE. `line` keeps its advanced value, and scanning resumes from there.
- All counters are unsigned and wrap naturally. Any parameter combination outside the ranges above is illegal.

## Timing
- Reset values: `line`=0, `column`=0, `hub_*` data=0, `hub_clk`=0, `hub_lat`=0, `hub_oe_n`=1, `hub_addr`=0, `frame_start`=0, state=IDLE.
- Reset mid-operation applies these values on the next edge. A partial line is discarded.
- Pattern latency: 0 cycles. The data register loads in the same cycle `column` is presented.
- Data hold at the panel:
  - `hub_*` data changes only on the first cycle of a low phase.
  - It is stable ≥CLK_DIV cycles before and after each `hub_clk` rising edge.
- Line period = COLS·2·CLK_DIV + LATCH_CYCLES + ON_CYCLES cycles. With defaults: 128+2+256 = 386 cycles.
- Frame period = LINES × line period. With defaults: 12352 cycles.
- `hub_addr` changes only while `hub_oe_n`=1 and only on LATCH entry.
- `frame_start` is asserted on the first SHIFT cycle of line 0.

## Structure
- Shared package `hub75_pkg`:
  - FSM state enum.
  - Panel constants: COLS=64, LINES=32.
  - Coordinate widths.
  - Default timing constants.
- Sub-module `hub75_timer`: a loadable down-counter with a done flag. It is reused for the phase, latch and display durations.
- The FSM, coordinate counters and output registers live in the top module.

## Test plan
- Reset check: assert `rst` for 3 cycles with `enable`=1.
  - → All outputs hold reset values during reset.
  - → The first `hub_clk` rise occurs at cycle 2 after `rst` drops (CLK_DIV=1).
- Shift check: pattern stub returns `r1`=`column[0]` and others 0.
  - → At line 0, 64 rising edges of `hub_clk` are seen.
  - → `hub_r1` sampled on the rising edges reads 0,1,0,1…
  - → `hub_oe_n`=1 throughout.
- Line timing: default parameters.
  - → Per line, `hub_lat` is high for exactly 2 cycles, then `hub_oe_n` is low for exactly 256 cycles.
  - → Line period = 386 cycles.
  - → `hub_addr`=0 on line 0, then increments.
- Wrap check: run 33 lines.
  - → `hub_addr` goes 0…31, 0.
  - → `frame_start` pulses exactly at cycle 0 and at cycle 12352.
- Disable mid-line: drop `enable` during SHIFT of line 5.
  - → Line 5 still latches and displays.
  - → The FSM then idles with `hub_oe_n`=1 and `line`=6.
  - → After re-enable, the next latch shows `hub_addr`=6.
- Divider check: CLK_DIV=3.
  - → `hub_clk` high for 3 and low for 3 cycles.
  - → Data changes only on the first low cycle.
  - → SHIFT lasts 384 cycles.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared constants, FSM state type and pixel struct for the HUB75 scan driver.
package hub75_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } hub_state_e;

  localparam int HUB_COLS  = 64;
  localparam int HUB_LINES = 32;
  localparam int COL_W     = $clog2(HUB_COLS);
  localparam int LINE_W    = $clog2(HUB_LINES);

  localparam int DEF_CLK_DIV      = 1;
  localparam int DEF_LATCH_CYCLES = 2;
  localparam int DEF_ON_CYCLES    = 256;

  typedef struct packed {
    logic r1;
    logic r2;
    logic g1;
    logic g2;
    logic b1;
    logic b2;
  } hub_rgb_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hub75_scan_driver_if.sv
// Pattern-source coordinates/colour bits and HUB75 panel pins in one bundle.
interface hub75_scan_driver_if import hub75_pkg::*; #(
  parameter int CW = COL_W,
  parameter int LW = LINE_W
) ();
  logic [LW-1:0] line;
  logic [CW-1:0] column;
  logic          r1, r2, g1, g2, b1, b2;
  logic          hub_r1, hub_r2, hub_g1, hub_g2, hub_b1, hub_b2;
  logic          hub_clk;
  logic          hub_lat;
  logic          hub_oe_n;
  logic [LW-1:0] hub_addr;
  logic          frame_start;

  modport master (
    output line, column,
    input  r1, r2, g1, g2, b1, b2,
    output hub_r1, hub_r2, hub_g1, hub_g2, hub_b1, hub_b2,
    output hub_clk, hub_lat, hub_oe_n, hub_addr, frame_start
  );

  modport slave (
    input  line, column,
    output r1, r2, g1, g2, b1, b2,
    input  hub_r1, hub_r2, hub_g1, hub_g2, hub_b1, hub_b2,
    input  hub_clk, hub_lat, hub_oe_n, hub_addr, frame_start
  );
endinterface

// File: rtl/hub75_timer.sv
// Loadable down-counter; a phase loaded with N-1 lasts N cycles, done flags the last one.
module hub75_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         done
);
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/hub75_scan_driver.sv
// 1/32-scan HUB75 driver: walks line/column for the pattern LUT, shifts, latches, displays.
module hub75_scan_driver import hub75_pkg::*; #(
  parameter int COLS         = HUB_COLS,
  parameter int LINES        = HUB_LINES,
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int ON_CYCLES    = DEF_ON_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  hub75_scan_driver_if.master bus
);
  localparam int CW    = $clog2(COLS);
  localparam int LW    = $clog2(LINES);
  localparam int TMR_W = $clog2(max3(CLK_DIV, LATCH_CYCLES, ON_CYCLES) + 1);

  localparam logic [TMR_W-1:0] DIV_LD = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] LAT_LD = TMR_W'(LATCH_CYCLES - 1);
  localparam logic [TMR_W-1:0] ON_LD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [CW-1:0]    COL_LAST  = CW'(COLS - 1);
  localparam logic [LW-1:0]    LINE_LAST = LW'(LINES - 1);

  hub_state_e       state, state_nxt;
  logic             ph_hi, ph_nxt;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val, tmr_cnt;
  logic             col_inc, line_inc;
  logic             first_low, lat_first;
  logic [CW-1:0]    column;
  logic [LW-1:0]    line;
  hub_rgb_t         pat, pix;
  logic             hub_clk_q, hub_lat_q, hub_oe_n_q, frame_start_q;
  logic [LW-1:0]    hub_addr_q;

  hub75_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .cnt      (tmr_cnt),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ph_nxt    = ph_hi;
    tmr_load  = 1'b0;
    tmr_val   = DIV_LD;
    col_inc   = 1'b0;
    line_inc  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt = ST_SHIFT;
          ph_nxt    = 1'b0;
          tmr_load  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (!ph_hi) begin
            ph_nxt = 1'b1;
          end else begin
            ph_nxt  = 1'b0;
            col_inc = 1'b1;
            if (column == COL_LAST) begin
              state_nxt = ST_LATCH;
              tmr_val   = LAT_LD;
            end
          end
        end
      end
      ST_LATCH: begin
        if (tmr_done) begin
          state_nxt = ST_DISPLAY;
          tmr_load  = 1'b1;
          tmr_val   = ON_LD;
        end
      end
      ST_DISPLAY: begin
        if (tmr_done) begin
          line_inc = 1'b1;
          if (enable) begin
            state_nxt = ST_SHIFT;
            ph_nxt    = 1'b0;
            tmr_load  = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign first_low = (state == ST_SHIFT) && !ph_hi && (tmr_cnt == DIV_LD);
  assign lat_first = (state == ST_LATCH) && (tmr_cnt == LAT_LD);

  assign pat = '{r1: bus.r1, r2: bus.r2, g1: bus.g1, g2: bus.g2, b1: bus.b1, b2: bus.b2};

  // Panel pins are registered from the current state, so the whole panel view
  // trails the FSM by one cycle; data therefore lands exactly as hub_clk falls.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_hi         <= 1'b0;
      column        <= '0;
      line          <= '0;
      pix           <= '0;
      hub_clk_q     <= 1'b0;
      hub_lat_q     <= 1'b0;
      hub_oe_n_q    <= 1'b1;
      hub_addr_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      ph_hi <= ph_nxt;
      if (col_inc)  column <= (column == COL_LAST)  ? '0 : column + 1'b1;
      if (line_inc) line   <= (line   == LINE_LAST) ? '0 : line + 1'b1;
      if (first_low) pix <= pat;
      if (lat_first) hub_addr_q <= line;
      hub_clk_q     <= (state == ST_SHIFT) && ph_hi;
      hub_lat_q     <= (state == ST_LATCH);
      hub_oe_n_q    <= (state != ST_DISPLAY);
      frame_start_q <= first_low && (column == '0) && (line == '0);
    end
  end

  assign bus.line        = line;
  assign bus.column      = column;
  assign bus.hub_r1      = pix.r1;
  assign bus.hub_r2      = pix.r2;
  assign bus.hub_g1      = pix.g1;
  assign bus.hub_g2      = pix.g2;
  assign bus.hub_b1      = pix.b1;
  assign bus.hub_b2      = pix.b2;
  assign bus.hub_clk     = hub_clk_q;
  assign bus.hub_lat     = hub_lat_q;
  assign bus.hub_oe_n    = hub_oe_n_q;
  assign bus.hub_addr    = hub_addr_q;
  assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver: reset, shift data, line/frame timing, disable, divider.
module tb_hub75_scan_driver;
  import hub75_pkg::*;

  localparam int LINE_P  = 386;
  localparam int FRAME_P = 12352;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hub75_scan_driver_if bus1 ();
  hub75_scan_driver_if bus3 ();

  hub75_scan_driver dut (.clk(clk), .rst(rst), .enable(enable), .bus(bus1));
  hub75_scan_driver #(.CLK_DIV(3)) dut3 (.clk(clk), .rst(rst), .enable(enable), .bus(bus3));

  // Pattern stub: bits chosen so adjacent pixels and lines differ.
  function automatic logic [5:0] pat(input logic [4:0] l, input logic [5:0] c);
    return {c[0], c[1], l[0], ~c[0], c[5], l[1]};
  endfunction

  always_comb {bus1.r1, bus1.r2, bus1.g1, bus1.g2, bus1.b1, bus1.b2} = pat(bus1.line, bus1.column);
  always_comb {bus3.r1, bus3.r2, bus3.g1, bus3.g2, bus3.b1, bus3.b2} = pat(bus3.line, bus3.column);

  logic [5:0] dat1, dat3;
  assign dat1 = {bus1.hub_r1, bus1.hub_r2, bus1.hub_g1, bus1.hub_g2, bus1.hub_b1, bus1.hub_b2};
  assign dat3 = {bus3.hub_r1, bus3.hub_r2, bus3.hub_g1, bus3.hub_g2, bus3.hub_b1, bus3.hub_b2};

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic wait_lat_rise(input int budget, output bit seen);
    logic p;
    p = bus1.hub_lat;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus1.hub_lat && !p) seen = 1'b1;
      p = bus1.hub_lat;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ovec;
    logic        p_clk, p_lat, p_oe, seen;
    logic [4:0]  p_addr;
    logic [5:0]  p_dat;
    int first_rise, rise_n, lat_n, last_lat, lat_run, oe_run, fs_n, fs_first, cnt, act;
    int fs_c, lat_c, hi_run, lo_run, rises;

    // reset: all panel/coordinate outputs at reset values while rst held
    rst = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ovec = {6'd0, bus1.line, bus1.column, dat1, bus1.hub_clk, bus1.hub_lat,
              bus1.hub_oe_n, bus1.hub_addr, bus1.frame_start};
      chk("rst_outputs", ovec, 32'h40);
    end
    rst = 1'b0;

    // 33 lines of free-running scan, index 0 = first edge with rst low
    first_rise = -1; rise_n = 0; lat_n = 0; last_lat = 0; lat_run = 0; oe_run = 0;
    fs_n = 0; fs_first = 0;
    p_clk = 1'b0; p_lat = 1'b0; p_oe = 1'b1; p_addr = '0;
    for (int c = 0; c < 33 * LINE_P + 60; c++) begin
      @(negedge clk);
      if (bus1.hub_clk && !p_clk) begin
        if (first_rise < 0) begin
          first_rise = c;
          chk("first_rise", c, 2);
        end
        if (lat_n < 2) chk($sformatf("pix_l%0d_c%0d", lat_n, rise_n), dat1, pat(5'(lat_n), 6'(rise_n)));
        chk("oe_in_shift", bus1.hub_oe_n, 1);
        rise_n++;
      end
      if (bus1.hub_lat && !p_lat) begin
        chk($sformatf("addr_l%0d", lat_n), bus1.hub_addr, lat_n % 32);
        chk("rises_per_line", rise_n, 64);
        chk("oe_at_latch", bus1.hub_oe_n, 1);
        if (lat_n > 0) chk("line_period", c - last_lat, LINE_P);
        rise_n = 0;
        last_lat = c;
        lat_n++;
      end
      if (bus1.hub_lat) lat_run++;
      if (!bus1.hub_lat && p_lat) begin
        chk("lat_width", lat_run, 2);
        lat_run = 0;
      end
      if (!bus1.hub_oe_n) oe_run++;
      if (bus1.hub_oe_n && !p_oe) begin
        chk("oe_width", oe_run, 256);
        oe_run = 0;
      end
      if (bus1.frame_start) begin
        fs_n++;
        if (fs_n == 1) begin
          fs_first = c;
          chk("frame_start0", c, 1);
        end else begin
          chk("frame_period", c - fs_first, FRAME_P);
        end
      end
      if (bus1.hub_addr != p_addr) begin
        chk("addr_chg_oe", bus1.hub_oe_n, 1);
        chk("addr_chg_lat", bus1.hub_lat, 1);
      end
      p_clk = bus1.hub_clk; p_lat = bus1.hub_lat; p_oe = bus1.hub_oe_n; p_addr = bus1.hub_addr;
    end
    chk("lines_seen", lat_n, 33);
    chk("frame_pulses", fs_n, 2);

    // disable during SHIFT of line 5
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    p_oe = 1'b1;
    for (int c = 0; c < 6 * LINE_P && cnt < 5; c++) begin
      @(negedge clk);
      if (bus1.hub_oe_n && !p_oe) cnt++;
      p_oe = bus1.hub_oe_n;
    end
    chk("dis_lines_done", cnt, 5);
    repeat (10) @(negedge clk);
    chk("dis_line_in_shift", bus1.line, 5);
    enable = 1'b0;
    wait_lat_rise(300, seen);
    chk("dis_latch_seen", seen, 1);
    chk("dis_latch_addr", bus1.hub_addr, 5);
    oe_run = 0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (!bus1.hub_oe_n) oe_run++;
      else if (oe_run > 0) seen = 1'b1;
    end
    chk("dis_oe_width", oe_run, 256);
    act = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus1.hub_clk || bus1.hub_lat || !bus1.hub_oe_n) act++;
    end
    chk("idle_activity", act, 0);
    chk("idle_line", bus1.line, 6);
    enable = 1'b1;
    wait_lat_rise(400, seen);
    chk("resume_seen", seen, 1);
    chk("resume_addr", bus1.hub_addr, 6);

    // CLK_DIV=3 instance, first line
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fs_c = -1; lat_c = -1; hi_run = 0; lo_run = 0; rises = 0;
    p_clk = 1'b0; p_dat = dat3;
    for (int c = 0; c < 800 && lat_c < 0; c++) begin
      @(negedge clk);
      if (bus3.frame_start && fs_c < 0) fs_c = c;
      if (bus3.hub_lat && lat_c < 0) lat_c = c;
      if (dat3 != p_dat) chk("div_data_edge", (c == fs_c) || (!bus3.hub_clk && p_clk), 1);
      if (bus3.hub_clk) begin
        if (!p_clk) begin
          chk("div_low_len", lo_run, 3);
          chk($sformatf("div_pix_c%0d", rises), dat3, pat(5'd0, 6'(rises)));
          rises++;
        end
        hi_run++;
        lo_run = 0;
      end else begin
        if (p_clk) begin
          chk("div_high_len", hi_run, 3);
          hi_run = 0;
        end
        if (fs_c >= 0 && lat_c < 0) lo_run++;
      end
      p_clk = bus3.hub_clk;
      p_dat = dat3;
    end
    chk("div_rises", rises, 64);
    chk("div_shift_len", lat_c - fs_c, 384);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
